// File: rtl/icache_refill_pkg.sv
// Shared widths, state encoding and helpers for the instruction-cache line refill engine.
package icache_refill_pkg;

  localparam int unsigned I_INDEX_WIDTH = 6;
  localparam int unsigned I_WO_WIDTH    = 2;
  localparam int unsigned NWORDS        = 1 << I_WO_WIDTH;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StFill = 2'd2,
    StDone = 2'd3
  } refill_state_e;

  // Word offsets wrap naturally at the line boundary (critical-word-first order).
  function automatic logic [I_WO_WIDTH-1:0] wrap_inc(input logic [I_WO_WIDTH-1:0] offset);
    return offset + 1'b1;
  endfunction

endpackage

// File: rtl/icache_refill_ctr.sv
// Refill word-offset / beat counter: loads the critical offset, advances one word per beat and
// flags the last beat of the line.
module icache_refill_ctr
  import icache_refill_pkg::*;
#(
  parameter int unsigned NWords = NWORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [I_WO_WIDTH-1:0] load_offset_i,
  input  logic                  inc_i,
  output logic [I_WO_WIDTH-1:0] offset_o,
  output logic                  first_o,
  output logic                  last_o
);

  localparam logic [I_WO_WIDTH:0] LastCount = (I_WO_WIDTH + 1)'(NWords - 1);

  logic [I_WO_WIDTH-1:0] offset_d, offset_q;
  logic [I_WO_WIDTH:0]   count_d, count_q;

  always_comb begin
    offset_d = offset_q;
    count_d  = count_q;
    if (load_i) begin
      offset_d = load_offset_i;
      count_d  = '0;
    end else if (inc_i) begin
      offset_d = wrap_inc(offset_q);
      count_d  = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q <= '0;
      count_q  <= '0;
    end else begin
      offset_q <= offset_d;
      count_q  <= count_d;
    end
  end

  assign offset_o = offset_q;
  assign first_o  = (count_q == '0);
  assign last_o   = (count_q == LastCount);

endmodule

// File: rtl/icache_refill.sv
// I-cache miss refill engine: requests a line from memory, writes returned words critical-word
// first into the data RAM, forwards the critical word and finally writes the tag.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int unsigned dw     = 32,
  parameter int unsigned nwords = NWORDS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [I_INDEX_WIDTH-1:0] req_index,
  input  logic [I_WO_WIDTH-1:0]    req_offset,
  input  logic [1:0]               req_way,
  output logic                     mem_req,
  output logic [I_INDEX_WIDTH-1:0] mem_index,
  input  logic                     mem_ack,
  input  logic                     mem_rvalid,
  input  logic [dw-1:0]            mem_rdata,
  output logic [I_INDEX_WIDTH-1:0] ram_index,
  output logic [1:0]               ram_way,
  output logic [I_WO_WIDTH-1:0]    ram_offset,
  output logic [dw-1:0]            ram_din,
  output logic                     ram_we,
  output logic                     ram_en,
  output logic                     crit_valid,
  output logic [dw-1:0]            crit_data,
  output logic                     tag_we,
  output logic                     done
);

  refill_state_e             state_d, state_q;
  logic [I_INDEX_WIDTH-1:0]  index_d, index_q;
  logic [1:0]                way_d, way_q;
  logic                      req_ready_d, req_ready_q;
  logic                      mem_req_d, mem_req_q;
  logic                      tag_we_d, tag_we_q;
  logic                      done_d, done_q;

  logic                      accept;
  logic                      beat;
  logic [I_WO_WIDTH-1:0]     ctr_offset;
  logic                      ctr_first;
  logic                      ctr_last;

  assign accept = (state_q == StIdle) && req_valid;
  // Reset masks the beat so nothing reaches the RAM in the reset cycle itself.
  assign beat   = (state_q == StFill) && mem_rvalid && !rst;

  icache_refill_ctr #(
    .NWords(nwords)
  ) u_ctr (
    .clk          (clk),
    .rst          (rst),
    .load_i       (accept),
    .load_offset_i(req_offset),
    .inc_i        (beat),
    .offset_o     (ctr_offset),
    .first_o      (ctr_first),
    .last_o       (ctr_last)
  );

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    way_d   = way_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          index_d = req_index;
          way_d   = req_way;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_ack) state_d = StFill;
      end
      StFill: begin
        if (beat && ctr_last) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Strobes are registered from the next state so they align with the state they belong to.
    req_ready_d = (state_d == StIdle);
    mem_req_d   = (state_d == StReq);
    tag_we_d    = (state_d == StDone);
    done_d      = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      index_q     <= '0;
      way_q       <= '0;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      tag_we_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      way_q       <= way_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      tag_we_q    <= tag_we_d;
      done_q      <= done_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_index  = index_q;
  assign ram_index  = index_q;
  assign ram_way    = way_q;
  assign ram_offset = ctr_offset;
  assign ram_we     = beat;
  assign ram_en     = beat;
  assign ram_din    = beat ? mem_rdata : '0;
  assign crit_valid = beat && ctr_first;
  assign crit_data  = crit_valid ? mem_rdata : '0;
  assign tag_we     = tag_we_q;
  assign done       = done_q;

  a_we_only_in_fill : assert property (@(posedge clk) disable iff (rst)
    ram_we |-> (state_q == StFill));
  a_no_we_with_tag : assert property (@(posedge clk) disable iff (rst)
    !(ram_we && tag_we));

endmodule

// File: tb/tb_icache_refill.sv
// Randomized bench for icache_refill with a transaction-level line model.
module tb_icache_refill;
  import icache_refill_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     req_valid;
  logic                     req_ready;
  logic [I_INDEX_WIDTH-1:0] req_index;
  logic [I_WO_WIDTH-1:0]    req_offset;
  logic [1:0]               req_way;
  logic                     mem_req;
  logic [I_INDEX_WIDTH-1:0] mem_index;
  logic                     mem_ack;
  logic                     mem_rvalid;
  logic [31:0]              mem_rdata;
  logic [I_INDEX_WIDTH-1:0] ram_index;
  logic [1:0]               ram_way;
  logic [I_WO_WIDTH-1:0]    ram_offset;
  logic [31:0]              ram_din;
  logic                     ram_we;
  logic                     ram_en;
  logic                     crit_valid;
  logic [31:0]              crit_data;
  logic                     tag_we;
  logic                     done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  icache_refill dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_index (req_index),
    .req_offset(req_offset),
    .req_way   (req_way),
    .mem_req   (mem_req),
    .mem_index (mem_index),
    .mem_ack   (mem_ack),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .ram_index (ram_index),
    .ram_way   (ram_way),
    .ram_offset(ram_offset),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_en    (ram_en),
    .crit_valid(crit_valid),
    .crit_data (crit_data),
    .tag_we    (tag_we),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rand_req_fields();
    req_index  = I_INDEX_WIDTH'($urandom);
    req_offset = I_WO_WIDTH'($urandom);
    req_way    = 2'($urandom);
  endtask

  // One refill as seen from outside: accept, request phase, beats in critical-word-first order,
  // one done cycle. abort_after >= 0 asserts rst once that many beats have been written.
  task automatic do_refill(input logic [I_INDEX_WIDTH-1:0] idx, input logic [I_WO_WIDTH-1:0] off,
                           input logic [1:0] way, input int ack_dly, input logic [31:0] pat,
                           input int pat_len, input int abort_after, input bit hold_req);
    int wr_cnt[NWORDS];
    logic [31:0] line[NWORDS];
    int beats;
    int cyc;
    bit rv;
    int exp_off;
    for (int i = 0; i < NWORDS; i++) begin
      wr_cnt[i] = 0;
      line[i]   = '0;
    end

    // Idle cycle: request accepted; stray ack/rvalid must be ignored.
    @(negedge clk);
    rst        = 1'b0;
    req_valid  = 1'b1;
    req_index  = idx;
    req_offset = off;
    req_way    = way;
    mem_ack    = 1'($urandom);
    mem_rvalid = 1'($urandom);
    mem_rdata  = $urandom;
    #1;
    check_eq("idle_ready", req_ready, 1);
    check_eq("idle_we", ram_we, 0);
    check_eq("idle_memreq", mem_req, 0);
    check_eq("idle_tagwe", tag_we | done, 0);

    for (int c = 0; c <= ack_dly; c++) begin
      @(negedge clk);
      req_valid = hold_req ? 1'b1 : 1'($urandom);
      rand_req_fields();
      mem_ack    = (c == ack_dly);
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      #1;
      check_eq("req_memreq", mem_req, 1);
      check_eq("req_index", mem_index, idx);
      check_eq("req_ready", req_ready, 0);
      check_eq("req_we", ram_we | crit_valid | tag_we | done, 0);
    end

    beats = 0;
    cyc   = 0;
    while (beats < NWORDS) begin
      @(negedge clk);
      req_valid = hold_req ? 1'b1 : 1'($urandom);
      rand_req_fields();
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
      if (cyc < pat_len) rv = pat[cyc];
      else if (cyc > 30) rv = 1'b1;
      else rv = 1'($urandom);
      mem_rvalid = rv;
      if (abort_after >= 0 && beats == abort_after) begin
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        #1;
        check_eq("rst_we", ram_we | crit_valid, 0);
        @(negedge clk);
        rst        = 1'b0;
        req_valid  = 1'b0;
        mem_rvalid = 1'b1;
        mem_ack    = 1'b1;
        #1;
        check_eq("abort_ready", req_ready, 1);
        check_eq("abort_we", ram_we, 0);
        check_eq("abort_tag", tag_we | done, 0);
        check_eq("abort_memreq", mem_req, 0);
        check_eq("abort_off", ram_offset, 0);
        check_eq("abort_idx", mem_index, 0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          mem_rvalid = 1'($urandom);
          #1;
          check_eq("abort_quiet", tag_we | done | ram_we | mem_req, 0);
        end
        return;
      end
      #1;
      check_eq("fill_ready", req_ready, 0);
      check_eq("fill_strobes", mem_req | tag_we | done, 0);
      check_eq("fill_ridx", ram_index, idx);
      check_eq("fill_rway", ram_way, way);
      check_eq("fill_we", ram_we, rv);
      check_eq("fill_en", ram_en, rv);
      if (rv) begin
        exp_off = (int'(off) + beats) % NWORDS;
        check_eq("fill_off", ram_offset, exp_off);
        check_eq("fill_din", ram_din, mem_rdata);
        check_eq("fill_crit", crit_valid, beats == 0);
        if (beats == 0) check_eq("fill_critdata", crit_data, mem_rdata);
        if (ram_we) begin
          wr_cnt[ram_offset]++;
          line[ram_offset] = ram_din;
        end
        beats++;
      end else begin
        check_eq("gap_crit", crit_valid, 0);
      end
      cyc++;
    end

    @(negedge clk);
    req_valid  = hold_req ? 1'b1 : 1'b0;
    rand_req_fields();
    mem_ack    = 1'($urandom);
    mem_rvalid = 1'($urandom);
    #1;
    check_eq("done_tag", tag_we, 1);
    check_eq("done_done", done, 1);
    check_eq("done_we", ram_we, 0);
    check_eq("done_ready", req_ready, 0);
    check_eq("done_memreq", mem_req, 0);
    for (int i = 0; i < NWORDS; i++) begin
      check_eq("line_wrcnt", wr_cnt[i], 1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_index  = '0;
    req_offset = '0;
    req_way    = '0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_strobes", {mem_req, ram_we, ram_en, crit_valid, tag_we, done}, 0);
    check_eq("rst_addr", {mem_index, ram_index, ram_way, ram_offset}, 0);
    check_eq("rst_data", {ram_din, crit_data}, 0);

    do_refill(6'd5, 2'd0, 2'd2, 3, 32'hF, 4, -1, 1'b0);
    do_refill(6'($urandom), 2'd2, 2'd1, 1, 32'hF, 4, -1, 1'b0);
    do_refill(6'($urandom), 2'd1, 2'd3, 0, 32'h59, 7, -1, 1'b0);
    do_refill(6'($urandom), 2'd3, 2'd0, 2, 32'hF, 4, 2, 1'b0);
    do_refill(6'($urandom), 2'd0, 2'd1, 1, 32'h0, 0, -1, 1'b1);
    do_refill(6'($urandom), 2'd2, 2'd2, 0, 32'h0, 0, -1, 1'b1);

    for (int t = 0; t < 40; t++) begin
      do_refill(6'($urandom), 2'($urandom), 2'($urandom), int'($urandom_range(0, 5)), 32'h0, 0,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
                1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
